uart_cmd_sequencer: RTL
=======================

// Module: uart_cmd_sequencer
// PURPOSE
//  Frame parser and sequencer between the UART receiver and the FIFO/processor datapath.
//  Consumes received bytes framed as SOF LEN CMD [payload] EOF and validates each frame.
//  Configures the matrix size, streams matrix/vector payload into FIFO A/B, and issues
//  start/clear pulses to the processor. Acknowledges every received byte via clear_interrupt.
// PARAMETERS
//  DW     8      byte width of rx_data / push_data
//  MAX_N  8      largest matrix dimension accepted by CMD 1
//  SOF    8'hFE  start-of-frame byte
//  EOF    8'hEF  end-of-frame byte
// PORTS
//  clk              in   1                   system clock, rising edge
//  rst              in   1                   asynchronous, active-high reset
//  rx_interrupt     in   1                   UART byte-valid strobe (level, >=1 cycle)
//  rx_data          in   DW                  received byte, valid while rx_interrupt=1
//  clear_interrupt  out  1                   1-cycle acknowledge of the consumed byte
//  working          in   1                   processor busy
//  full_A           in   1                   matrix FIFO full
//  full_B           in   1                   vector FIFO full
//  push_A           out  1                   write strobe, matrix FIFO
//  push_B           out  1                   write strobe, vector FIFO
//  push_data        out  DW                  data for push_A/push_B
//  mat_n            out  $clog2(MAX_N+1)     configured dimension N
//  start_proc       out  1                   1-cycle processor start pulse
//  clear_proc       out  1                   1-cycle datapath clear pulse
//  frame_err        out  1                   1-cycle pulse, frame rejected
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, mat_n=0, counters 0. Reset mid-frame aborts it
//    with no pulses; FIFO pushes already issued stay issued.
//  - Accept: byte consumed at the edge where rx_interrupt=1 and clear_interrupt=0.
//    All outputs are registered and appear the cycle after acceptance (latency 1).
//    clear_interrupt is high exactly that cycle. A strobe held high is consumed once.
//  - IDLE: byte==SOF -> LEN. Any other byte is discarded silently (acked, no error).
//  - LEN: store LEN -> CMD.
//  - CMD: CMD must be 1..5. Required LEN and payload count P are:
//      CMD1 set N:      LEN=3, P=1.
//      CMD2 start:      LEN=2, P=0.
//      CMD3 clear:      LEN=2, P=0.
//      CMD4 load mat:   LEN=3, P=N*N.
//      CMD5 load vec:   LEN=3, P=N.
//    Go to ERR if: the LEN is wrong, CMD is 4/5 with mat_n=0, or CMD is 2/4/5 while
//    working=1. Otherwise -> PAYLOAD if P>0, else -> END.
//  - PAYLOAD: the counter is loaded with P and decremented per byte; the last byte -> END.
//      CMD1: byte is held pending. The value must be 1..MAX_N, else ERR.
//      CMD4/5: each byte drives push_A (CMD4) or push_B (CMD5) for 1 cycle with
//        push_data=byte. If the target full_* is 1 at acceptance: no push, -> ERR.
//      P computed as N*N, width 2*$clog2(MAX_N+1), no wrap.
//  - END: byte==EOF executes the command in the next cycle:
//      CMD1 mat_n<=pending; CMD2 start_proc=1; CMD3 clear_proc=1.
//    CMD4/5 completes with no pulse. Any byte other than EOF -> ERR. No rollback of
//    pushes already made.
//  - ERR: no state is held. On the faulting byte, frame_err pulses with its
//    clear_interrupt, no other action, state->IDLE. Following bytes are discarded until SOF.
//  - A SOF byte inside a frame is treated as data/LEN/CMD, never as a resync.
//  - push_A/push_B/start_proc/clear_proc/frame_err are mutually exclusive. Each is at
//    most 1 cycle per accepted byte.
//  - working and full_* are sampled only on accept cycles.
// TESTING
//  1 FE 03 01 04 EF -> 5 clear_interrupt pulses; mat_n=4 the cycle after the EF ack;
//    no frame_err.
//  2 After 1: FE 03 04 + bytes 01..10 + EF -> 16 push_A, push_data 01..10 in order;
//    FE 03 05 11 12 13 14 EF -> 4 push_B (11..14); no errors.
//  3 FE 02 02 EF with working=0 -> one start_proc pulse. The same frame with
//    working=1 -> frame_err on the CMD byte, no start_proc.
//  4 Errors each give 1 frame_err and 0 pushes:
//      FE 02 03 00 (missing EOF); FE 03 01 09 EF (N>MAX_N); FE 02 07 EF (bad CMD);
//      FE 03 04 with mat_n=0.
//    After each, FE 02 03 EF -> clear_proc.
//  5 Backpressure: CMD4 with full_A=1 on the 3rd payload byte -> 2 pushes then
//    frame_err. Stray bytes 55 AA in IDLE -> acked only.
//  6 Assert rst after CMD4's 5th payload byte -> outputs 0, mat_n=0, IDLE.
//    FE 03 01 02 EF then works.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// Frame parser between the UART receiver and the matrix/vector FIFOs and processor.
// Frames are SOF LEN CMD [payload] EOF; every consumed byte is acknowledged on clear_interrupt.
//
// state     | meaning
// S_IDLE    | waiting for SOF, other bytes discarded
// S_LEN     | next byte is the frame length
// S_CMD     | next byte is the command, validated against LEN/mat_n/working
// S_PAYLOAD | counting down payload bytes (N value or FIFO data)
// S_END     | next byte must be EOF, then the command executes
module uart_cmd_sequencer #(
  parameter int             DW    = 8,
  parameter int             MAX_N = 8,
  parameter logic [DW-1:0]  SOF   = 8'hFE,
  parameter logic [DW-1:0]  EOF   = 8'hEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_interrupt,
  input  logic [DW-1:0]                  rx_data,
  output logic                           clear_interrupt,
  input  logic                           working,
  input  logic                           full_A,
  input  logic                           full_B,
  output logic                           push_A,
  output logic                           push_B,
  output logic [DW-1:0]                  push_data,
  output logic [$clog2(MAX_N+1)-1:0]     mat_n,
  output logic                           start_proc,
  output logic                           clear_proc,
  output logic                           frame_err
);

  localparam int NW = $clog2(MAX_N+1);
  localparam int CW = 2*NW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD,
    S_PAYLOAD,
    S_END
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   len_q, len_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   pend_q, pend_d;
  logic            rx_seen_q, rx_seen_d;
  logic            ack_q, ack_d;
  logic            push_a_q, push_a_d;
  logic            push_b_q, push_b_d;
  logic [DW-1:0]   push_data_q, push_data_d;
  logic [NW-1:0]   mat_n_q, mat_n_d;
  logic            start_q, start_d;
  logic            clr_q, clr_d;
  logic            err_q, err_d;

  logic            accept;
  logic [CW-1:0]   n_ext;
  logic [CW-1:0]   p_nn;
  logic            n_valid;

  // A strobe held high is consumed once; rx_seen re-arms only after it drops.
  assign accept  = rx_interrupt & ~rx_seen_q & ~ack_q;
  assign n_ext   = CW'(mat_n_q);
  assign p_nn    = n_ext * n_ext;
  assign n_valid = (rx_data >= DW'(1)) && (rx_data <= DW'(MAX_N));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    rx_seen_d   = rx_interrupt;
    ack_d       = accept;
    push_a_d    = 1'b0;
    push_b_d    = 1'b0;
    push_data_d = push_data_q;
    mat_n_d     = mat_n_q;
    start_d     = 1'b0;
    clr_d       = 1'b0;
    err_d       = 1'b0;

    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == SOF) state_d = S_LEN;
        end

        S_LEN: begin
          len_d   = rx_data;
          state_d = S_CMD;
        end

        S_CMD: begin
          cmd_d   = rx_data[2:0];
          state_d = S_PAYLOAD;
          case (rx_data)
            DW'(1): begin
              cnt_d = CW'(1);
              if (len_q != DW'(3)) err_d = 1'b1;
            end
            DW'(2): begin
              state_d = S_END;
              if (len_q != DW'(2) || working) err_d = 1'b1;
            end
            DW'(3): begin
              state_d = S_END;
              if (len_q != DW'(2)) err_d = 1'b1;
            end
            DW'(4): begin
              cnt_d = p_nn;
              if (len_q != DW'(3) || mat_n_q == '0 || working) err_d = 1'b1;
            end
            DW'(5): begin
              cnt_d = n_ext;
              if (len_q != DW'(3) || mat_n_q == '0 || working) err_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
          if (err_d) state_d = S_IDLE;
        end

        S_PAYLOAD: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_END;
          case (cmd_q)
            3'd1: begin
              if (n_valid) pend_d = rx_data[NW-1:0];
              else         err_d  = 1'b1;
            end
            3'd4: begin
              if (full_A) err_d = 1'b1;
              else begin
                push_a_d    = 1'b1;
                push_data_d = rx_data;
              end
            end
            3'd5: begin
              if (full_B) err_d = 1'b1;
              else begin
                push_b_d    = 1'b1;
                push_data_d = rx_data;
              end
            end
            default: err_d = 1'b1;
          endcase
          if (err_d) state_d = S_IDLE;
        end

        S_END: begin
          state_d = S_IDLE;
          if (rx_data == EOF) begin
            case (cmd_q)
              3'd1:    mat_n_d = pend_q;
              3'd2:    start_d = 1'b1;
              3'd3:    clr_d   = 1'b1;
              default: ;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      rx_seen_q   <= 1'b0;
      ack_q       <= 1'b0;
      push_a_q    <= 1'b0;
      push_b_q    <= 1'b0;
      push_data_q <= '0;
      mat_n_q     <= '0;
      start_q     <= 1'b0;
      clr_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      rx_seen_q   <= rx_seen_d;
      ack_q       <= ack_d;
      push_a_q    <= push_a_d;
      push_b_q    <= push_b_d;
      push_data_q <= push_data_d;
      mat_n_q     <= mat_n_d;
      start_q     <= start_d;
      clr_q       <= clr_d;
      err_q       <= err_d;
    end
  end

  assign clear_interrupt = ack_q;
  assign push_A          = push_a_q;
  assign push_B          = push_b_q;
  assign push_data       = push_data_q;
  assign mat_n           = mat_n_q;
  assign start_proc      = start_q;
  assign clear_proc      = clr_q;
  assign frame_err       = err_q;

endmodule
